// File: rtl/sdes_key_sched_if.sv
// Key-load request and subkey result bundle between the S-DES key schedule and its consumer.
// The zeroize wire exists only when SDES_KEY_ZEROIZE_EN is defined.
interface sdes_key_sched_if #(
    parameter int CNT_W = 8
);
    logic             key_load;
    logic [9:0]       key_in;
    logic             busy;
    logic             keys_valid;
    logic [7:0]       k1;
    logic [7:0]       k2;
    logic             load_err;
    logic [CNT_W-1:0] sched_cnt;
`ifdef SDES_KEY_ZEROIZE_EN
    logic             zeroize;

    modport master (
        output key_load, key_in, zeroize,
        input  busy, keys_valid, k1, k2, load_err, sched_cnt
    );
    modport slave (
        input  key_load, key_in, zeroize,
        output busy, keys_valid, k1, k2, load_err, sched_cnt
    );
`else
    modport master (
        output key_load, key_in,
        input  busy, keys_valid, k1, k2, load_err, sched_cnt
    );
    modport slave (
        input  key_load, key_in,
        output busy, keys_valid, k1, k2, load_err, sched_cnt
    );
`endif
endinterface

// File: rtl/sdes_key_sched.sv
// S-DES key schedule: P10, LS-1+P8 -> k1, LS-2+P8 -> k2; keys_valid three edges after the sampling edge.
// Loads while busy are dropped and flagged on load_err; SDES_KEY_ZEROIZE_EN adds a synchronous zeroize.
module sdes_key_sched #(
    parameter logic [7:0] RST_K1 = 8'h00,
    parameter logic [7:0] RST_K2 = 8'h00,
    parameter int         CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    sdes_key_sched_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_P10, S_GEN1, S_GEN2} state_t;

    state_t           state_q, state_d;
    logic [9:0]       kreg_q, kreg_d;
    logic [7:0]       k1_q, k1_d;
    logic [7:0]       k2_q, k2_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy;

    // Vector bit (10-n) holds S-DES bit n, so bit 1 is the MSB.
    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [9:0] ls1(input logic [9:0] k);
        return {k[8:5], k[9], k[3:0], k[4]};
    endfunction

    function automatic logic [9:0] ls2(input logic [9:0] k);
        return {k[7:5], k[9:8], k[2:0], k[4:3]};
    endfunction

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        kreg_d  = kreg_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        if (busy) begin
            err_d = bus.key_load;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.key_load) begin
                    kreg_d  = p10(bus.key_in);
                    valid_d = 1'b0;
                    state_d = S_P10;
                end
            end
            S_P10: begin
                kreg_d  = ls1(kreg_q);
                state_d = S_GEN1;
            end
            S_GEN1: begin
                k1_d    = p8(kreg_q);
                kreg_d  = ls2(kreg_q);
                state_d = S_GEN2;
            end
            S_GEN2: begin
                k2_d    = p8(kreg_q);
                valid_d = 1'b1;
                cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SDES_KEY_ZEROIZE_EN
        // Zeroize overrides everything, including a load in the same cycle.
        if (bus.zeroize) begin
            state_d = S_IDLE;
            kreg_d  = '0;
            k1_d    = RST_K1;
            k2_d    = RST_K2;
            valid_d = 1'b0;
            err_d   = 1'b0;
            cnt_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            kreg_q  <= '0;
            k1_q    <= RST_K1;
            k2_q    <= RST_K2;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kreg_q  <= kreg_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy       = busy;
    assign bus.keys_valid = valid_q;
    assign bus.k1         = k1_q;
    assign bus.k2         = k2_q;
    assign bus.load_err   = err_q;
    assign bus.sched_cnt  = cnt_q;
endmodule

// File: tb/tb_sdes_key_sched.sv
// Bench for sdes_key_sched: random keys against a table-driven S-DES subkey model, plus timing/corner scenarios.
module tb_sdes_key_sched;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0]       mk1, mk2;
    logic [CNT_W-1:0] mcnt;

    int p10_t[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    int p8_t[8]   = '{6, 3, 7, 4, 8, 5, 10, 9};

    sdes_key_sched_if #(.CNT_W(CNT_W)) bus();

    sdes_key_sched #(
        .RST_K1(8'h00),
        .RST_K2(8'h00),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Subkey = P8(rotate halves of P10(key) by total shift); shift 1 gives K1, 3 gives K2.
    function automatic logic [7:0] ref_subkey(input logic [9:0] key, input int shift);
        bit         b[11];
        bit         c[11];
        bit         d[11];
        logic [7:0] r;
        for (int n = 1; n <= 10; n++) b[n] = key[10-n];
        for (int i = 1; i <= 10; i++) c[i] = b[p10_t[i-1]];
        for (int i = 1; i <= 5; i++) begin
            d[i]   = c[((i - 1 + shift) % 5) + 1];
            d[i+5] = c[((i - 1 + shift) % 5) + 6];
        end
        r = '0;
        for (int i = 1; i <= 8; i++) r[8-i] = d[p8_t[i-1]];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        bus.key_load = 1'b0;
        bus.key_in   = '0;
`ifdef SDES_KEY_ZEROIZE_EN
        bus.zeroize  = 1'b0;
`endif
        tick;
        tick;
        rstn = 1'b1;
        mk1  = '0;
        mk2  = '0;
        mcnt = '0;
    endtask

    // One-cycle load from IDLE; checks the whole schedule timeline and updates the model.
    task automatic run_schedule(input logic [9:0] key, input string tag);
        logic [7:0] e1, e2;
        e1 = ref_subkey(key, 1);
        e2 = ref_subkey(key, 3);
        bus.key_in   = key;
        bus.key_load = 1'b1;
        tick;
        bus.key_load = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.keys_valid !== 1'b0 || bus.k1 !== mk1 || bus.k2 !== mk2) begin
            n_fail++;
            $display("FAIL %s start: busy=%b valid=%b k1=%h k2=%h, want busy=1 valid=0 k1=%h k2=%h",
                     tag, bus.busy, bus.keys_valid, bus.k1, bus.k2, mk1, mk2);
        end
        tick;
        tick;
        n_tests++;
        if (bus.k1 !== e1 || bus.keys_valid !== 1'b0 || bus.load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s k1: k1=%h valid=%b err=%b, want k1=%h valid=0 err=0",
                     tag, bus.k1, bus.keys_valid, bus.load_err, e1);
        end
        tick;
        if (mcnt != '1) mcnt = mcnt + 1'b1;
        mk1 = e1;
        mk2 = e2;
        n_tests++;
        if (bus.keys_valid !== 1'b1 || bus.busy !== 1'b0 || bus.k2 !== e2 || bus.sched_cnt !== mcnt) begin
            n_fail++;
            $display("FAIL %s done: valid=%b busy=%b k2=%h cnt=%0d, want valid=1 busy=0 k2=%h cnt=%0d",
                     tag, bus.keys_valid, bus.busy, bus.k2, bus.sched_cnt, e2, mcnt);
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.keys_valid !== 1'b0 || bus.k1 !== 8'h00 || bus.k2 !== 8'h00 ||
            bus.load_err !== 1'b0 || bus.sched_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b valid=%b k1=%h k2=%h err=%b cnt=%0d, want all zero",
                     bus.busy, bus.keys_valid, bus.k1, bus.k2, bus.load_err, bus.sched_cnt);
        end
    endtask

    task automatic test_known_vector;
        run_schedule(10'b1010000010, "known");
        n_tests++;
        if (bus.k1 !== 8'b10100100 || bus.k2 !== 8'b01000011 || bus.sched_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL known_const: k1=%b k2=%b cnt=%0d, want k1=10100100 k2=01000011 cnt=1",
                     bus.k1, bus.k2, bus.sched_cnt);
        end
    endtask

    task automatic test_edge_keys;
        run_schedule(10'h000, "zero_key");
        n_tests++;
        if (bus.k1 !== 8'h00 || bus.k2 !== 8'h00) begin
            n_fail++;
            $display("FAIL zero_key_const: k1=%h k2=%h, want 00 00", bus.k1, bus.k2);
        end
        run_schedule(10'h3FF, "ones_key");
        n_tests++;
        if (bus.k1 !== 8'hFF || bus.k2 !== 8'hFF) begin
            n_fail++;
            $display("FAIL ones_key_const: k1=%h k2=%h, want FF FF", bus.k1, bus.k2);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick;
            run_schedule(10'($urandom), "random");
        end
    endtask

    task automatic test_load_while_busy;
        logic [9:0] a, b;
        logic [7:0] e1, e2;
        a  = 10'($urandom);
        b  = ~a;
        e1 = ref_subkey(a, 1);
        e2 = ref_subkey(a, 3);
        bus.key_in   = a;
        bus.key_load = 1'b1;
        tick;
        bus.key_in = b;
        tick;
        n_tests++;
        if (bus.load_err !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_load_1: err=%b busy=%b, want err=1 busy=1", bus.load_err, bus.busy);
        end
        tick;
        bus.key_load = 1'b0;
        n_tests++;
        if (bus.load_err !== 1'b1 || bus.k1 !== e1) begin
            n_fail++;
            $display("FAIL busy_load_2: err=%b k1=%h, want err=1 k1=%h", bus.load_err, bus.k1, e1);
        end
        tick;
        if (mcnt != '1) mcnt = mcnt + 1'b1;
        mk1 = e1;
        mk2 = e2;
        n_tests++;
        if (bus.load_err !== 1'b0 || bus.keys_valid !== 1'b1 || bus.k2 !== e2 || bus.sched_cnt !== mcnt) begin
            n_fail++;
            $display("FAIL busy_load_done: err=%b valid=%b k2=%h cnt=%0d, want err=0 valid=1 k2=%h cnt=%0d",
                     bus.load_err, bus.keys_valid, bus.k2, bus.sched_cnt, e2, mcnt);
        end
        tick;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.keys_valid !== 1'b1 || bus.sched_cnt !== mcnt) begin
            n_fail++;
            $display("FAIL busy_load_idle: busy=%b valid=%b cnt=%0d, want busy=0 valid=1 cnt=%0d",
                     bus.busy, bus.keys_valid, bus.sched_cnt, mcnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] key;
        do_reset;
        key = 10'($urandom);
        bus.key_in   = key;
        bus.key_load = 1'b1;
        for (int c = 0; c < 16; c++) begin
            logic done;
            logic exp_err;
            tick;
            done    = (c % 4 == 3);
            exp_err = (c % 4 != 0);
            if (done && mcnt != '1) mcnt = mcnt + 1'b1;
            n_tests++;
            if (bus.busy !== !done || bus.keys_valid !== done || bus.load_err !== exp_err ||
                bus.sched_cnt !== mcnt) begin
                n_fail++;
                $display("FAIL b2b c=%0d: busy=%b valid=%b err=%b cnt=%0d, want busy=%b valid=%b err=%b cnt=%0d",
                         c, bus.busy, bus.keys_valid, bus.load_err, bus.sched_cnt,
                         !done, done, exp_err, mcnt);
            end
        end
        bus.key_load = 1'b0;
        mk1 = ref_subkey(key, 1);
        mk2 = ref_subkey(key, 3);
        tick;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.keys_valid !== 1'b1 || bus.k1 !== mk1 || bus.k2 !== mk2 ||
            bus.sched_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL b2b_end: busy=%b valid=%b k1=%h k2=%h cnt=%0d, want 0 1 %h %h 3",
                     bus.busy, bus.keys_valid, bus.k1, bus.k2, bus.sched_cnt, mk1, mk2);
        end
    endtask

    task automatic test_async_reset;
        do_reset;
        run_schedule(10'b1010000010, "pre_reset");
        bus.key_in   = 10'h155;
        bus.key_load = 1'b1;
        tick;
        bus.key_load = 1'b0;
        tick;
        #2;
        rstn = 1'b0;
        #1;
        n_tests++;
        if (bus.k1 !== 8'h00 || bus.k2 !== 8'h00 || bus.keys_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.sched_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset: k1=%h k2=%h valid=%b busy=%b cnt=%0d, want all zero",
                     bus.k1, bus.k2, bus.keys_valid, bus.busy, bus.sched_cnt);
        end
        tick;
        rstn = 1'b1;
        mk1  = '0;
        mk2  = '0;
        mcnt = '0;
        run_schedule(10'($urandom), "post_reset");
    endtask

`ifdef SDES_KEY_ZEROIZE_EN
    task automatic test_zeroize;
        do_reset;
        run_schedule(10'($urandom) | 10'h001, "pre_zeroize");
        bus.zeroize  = 1'b1;
        bus.key_load = 1'b1;
        bus.key_in   = 10'h2A5;
        tick;
        bus.zeroize  = 1'b0;
        bus.key_load = 1'b0;
        mk1  = '0;
        mk2  = '0;
        mcnt = '0;
        n_tests++;
        if (bus.k1 !== 8'h00 || bus.k2 !== 8'h00 || bus.keys_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.sched_cnt !== '0 || bus.load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zeroize: k1=%h k2=%h valid=%b busy=%b cnt=%0d err=%b, want all zero",
                     bus.k1, bus.k2, bus.keys_valid, bus.busy, bus.sched_cnt, bus.load_err);
        end
        tick;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.keys_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zeroize_no_start: busy=%b valid=%b, want 0 0", bus.busy, bus.keys_valid);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_known_vector;
        test_edge_keys;
        test_random;
        test_load_while_busy;
        test_back_to_back;
        test_async_reset;
`ifdef SDES_KEY_ZEROIZE_EN
        test_zeroize;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
